// File: rtl/rgb_pack_writer.sv
// rgb_pack_writer: scales 16-bit RGB pixels to 8 bits per channel, packs two pixels per
// 64-bit word, buffers words in a first-word-fall-through FIFO and writes them out over a
// valid/ready port with an incrementing byte address.
// Build option: define RGB_PACK_BGR_ORDER_EN to pack pixels as {ALPHA, B8, G8, R8}.
module rgb_pack_writer #(
  parameter int         PIXEL_WIDTH = 16,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] ALPHA       = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_v,
  input  logic [PIXEL_WIDTH-1:0] red,
  input  logic [PIXEL_WIDTH-1:0] green,
  input  logic [PIXEL_WIDTH-1:0] blue,
  input  logic                   done,
  input  logic [31:0]            base_adr,
  input  logic [3:0]             out_shift,
  output logic [63:0]            wr_data,
  output logic [31:0]            wr_adr,
  output logic                   wr_en,
  input  logic                   wr_ready,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;
  state_t state;
  logic   nxt_started;

  // Rounded right shift on PIXEL_WIDTH+1 bits, saturating to 8 bits.
  function automatic logic [7:0] scale_ch(input logic [PIXEL_WIDTH-1:0] c, input logic [3:0] s);
    logic [PIXEL_WIDTH:0] rnd;
    logic [PIXEL_WIDTH:0] v;
    rnd = '0;
    if (s != 4'd0) rnd = (PIXEL_WIDTH+1)'(1) << (s - 4'd1);
    v = ({1'b0, c} + rnd) >> s;
    return (|v[PIXEL_WIDTH:8]) ? 8'hFF : v[7:0];
  endfunction

  logic [3:0]  shift_eff;
  logic [7:0]  r8, g8, b8;
  logic [31:0] pix_scaled;
  logic        first_pix, mark_in;

  assign shift_eff = (out_shift > 4'd8) ? 4'd8 : out_shift;
  assign r8 = scale_ch(red, shift_eff);
  assign g8 = scale_ch(green, shift_eff);
  assign b8 = scale_ch(blue, shift_eff);
`ifdef RGB_PACK_BGR_ORDER_EN
  assign pix_scaled = {ALPHA, b8, g8, r8};
`else
  assign pix_scaled = {ALPHA, r8, g8, b8};
`endif

  // A pixel opens a new frame when no frame is running and none has been started early.
  assign first_pix = data_v && ((state == IDLE) ||
                     ((state != RUN) && !nxt_started));
  // End-of-frame marker travels with the data so padding lands on the right frame.
  assign mark_in   = done && ((state == RUN) || ((state == IDLE) && data_v));

  logic        s1_v, s1_first, s1_mark;
  logic [31:0] s1_pix, s1_base;

  // Stage 1: register scaled pixel, frame-start tag with its base address, and end marker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_mark  <= 1'b0;
      s1_pix   <= '0;
      s1_base  <= '0;
    end else begin
      s1_v     <= data_v;
      s1_first <= first_pix;
      s1_mark  <= mark_in;
      s1_pix   <= pix_scaled;
      s1_base  <= base_adr;
    end
  end

  logic        half_v, half_first;
  logic [31:0] half_pix, half_base;
  logic        wd_v, wd_first;
  logic [63:0] wd_data;
  logic [31:0] wd_base;

  // Stage 2: pair pixels into words; the end marker pushes out a pending half word padded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_v     <= 1'b0;
      half_first <= 1'b0;
      half_pix   <= '0;
      half_base  <= '0;
      wd_v       <= 1'b0;
      wd_first   <= 1'b0;
      wd_data    <= '0;
      wd_base    <= '0;
    end else begin
      wd_v <= 1'b0;
      if (s1_v) begin
        if (half_v) begin
          wd_v     <= 1'b1;
          wd_data  <= {s1_pix, half_pix};
          wd_first <= half_first;
          wd_base  <= half_base;
          half_v   <= 1'b0;
        end else if (s1_mark) begin
          wd_v     <= 1'b1;
          wd_data  <= {32'h0, s1_pix};
          wd_first <= s1_first;
          wd_base  <= s1_base;
        end else begin
          half_v     <= 1'b1;
          half_pix   <= s1_pix;
          half_first <= s1_first;
          half_base  <= s1_base;
        end
      end else if (s1_mark && half_v) begin
        wd_v     <= 1'b1;
        wd_data  <= {32'h0, half_pix};
        wd_first <= half_first;
        wd_base  <= half_base;
        half_v   <= 1'b0;
      end
    end
  end

  logic [63:0]   mem_data [FIFO_DEPTH];
  logic [31:0]   mem_adr  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   adr_nxt, push_adr;
  logic          full, pop, do_push;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign wr_en    = (count != '0);
  assign pop      = wr_en && wr_ready;
  assign do_push  = wd_v && (!full || pop);
  assign push_adr = wd_first ? wd_base : adr_nxt;
  assign wr_data  = wr_en ? mem_data[rd_ptr] : '0;
  assign wr_adr   = wr_en ? mem_adr[rd_ptr] : '0;

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= wd_data;
      mem_adr[wr_ptr]  <= push_adr;
    end
  end

  // FIFO pointers, occupancy, address counter and sticky overflow; dropped words still
  // consume an address slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      adr_nxt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wd_v) adr_nxt <= push_adr + 32'd8;
      if (wd_v && full && !pop) overflow <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Frame sequencing with registered frame_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      nxt_started <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (data_v && done) state <= FLUSH;
          else if (data_v) state <= RUN;
          else if (done) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        RUN: if (done) state <= FLUSH;
        FLUSH: begin
          if (data_v) nxt_started <= 1'b1;
          if (s1_mark) state <= DRAIN;
        end
        DRAIN: begin
          if (data_v) nxt_started <= 1'b1;
          if ((count == '0) && !wd_v) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state       <= (nxt_started || data_v) ? RUN : IDLE;
          nxt_started <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_pack_writer.sv
// Scoreboard bench for rgb_pack_writer: the stimulus thread pushes expected writes from a
// behavioural model, an independent monitor pops and compares every accepted write.
module tb_rgb_pack_writer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_v = 1'b0;
  logic        done = 1'b0;
  logic        wr_ready = 1'b1;
  logic [15:0] red = '0, green = '0, blue = '0;
  logic [31:0] base_adr = '0;
  logic [3:0]  out_shift = '0;
  logic [63:0] wr_data;
  logic [31:0] wr_adr;
  logic        wr_en, frame_done, overflow;

  always #5 clk = ~clk;

  rgb_pack_writer dut (
    .clk(clk), .reset(reset), .data_v(data_v), .red(red), .green(green), .blue(blue),
    .done(done), .base_adr(base_adr), .out_shift(out_shift), .wr_data(wr_data),
    .wr_adr(wr_adr), .wr_en(wr_en), .wr_ready(wr_ready), .frame_done(frame_done),
    .overflow(overflow)
  );

  int n_cmp = 0, n_bad = 0;
  int fd_cnt = 0, fd_target = 0;
  int ready_mode = 0;
  logic [63:0] exp_d[$];
  logic [31:0] exp_a[$];

  logic [31:0] m_base;
  int          m_widx;
  int          m_keep = 1 << 30;
  logic        m_half_v = 1'b0;
  logic [31:0] m_half;
  logic        m_first = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_ch(input int unsigned c, input int unsigned s);
    int unsigned se, v;
    se = (s > 8) ? 8 : s;
    v  = (c + ((se == 0) ? 0 : (1 << (se - 1)))) / (1 << se);
    return (v > 255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [31:0] ref_pix(input logic [15:0] r, g, b, input logic [3:0] s);
`ifdef RGB_PACK_BGR_ORDER_EN
    return {8'hFF, ref_ch(b, s), ref_ch(g, s), ref_ch(r, s)};
`else
    return {8'hFF, ref_ch(r, s), ref_ch(g, s), ref_ch(b, s)};
`endif
  endfunction

  task automatic model_word(input logic [63:0] w);
    if (m_widx < m_keep) begin
      exp_d.push_back(w);
      exp_a.push_back(m_base + 32'(m_widx) * 32'd8);
    end
    m_widx++;
  endtask

  task automatic model_pix(input logic [31:0] p);
    if (!m_half_v) begin
      m_half   = p;
      m_half_v = 1'b1;
    end else begin
      model_word({p, m_half});
      m_half_v = 1'b0;
    end
  endtask

  task automatic model_done();
    if (m_half_v) begin
      model_word({32'h0, m_half});
      m_half_v = 1'b0;
    end
  endtask

  // Monitor: compares accepted writes, checks hold during stalls, counts frame_done.
  logic        stall_prev = 1'b0;
  logic [63:0] prev_d;
  logic [31:0] prev_a;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_data", wr_data, prev_d);
        check("stall_hold_adr", {32'h0, wr_adr}, {32'h0, prev_a});
      end
      if (wr_en && wr_ready) begin
        if (exp_d.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got adr %h data %h, expected no write", wr_adr, wr_data);
        end else begin
          check("wr_data", wr_data, exp_d.pop_front());
          check("wr_adr", {32'h0, wr_adr}, {32'h0, exp_a.pop_front()});
        end
      end
      if (frame_done) begin
        fd_cnt++;
        check("frame_done_pending_words", 64'(exp_d.size()), 64'd0);
      end
      stall_prev = wr_en && !wr_ready;
      prev_d     = wr_data;
      prev_a     = wr_adr;
    end
  end

  // Memory-side ready: 0 = always ready, 1 = random 75%, 2 = stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       wr_ready = 1'b1;
        2:       wr_ready = 1'b0;
        default: wr_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic begin_frame(input logic [31:0] base, input logic [3:0] sh);
    #1;
    base_adr = base;
    out_shift = sh;
    m_base = base;
    m_widx = 0;
    m_half_v = 1'b0;
    m_first = 1'b1;
  endtask

  task automatic send(input logic [15:0] r, g, b, input logic dn);
    @(posedge clk);
    #1;
    if (!m_first) base_adr = $urandom();
    m_first = 1'b0;
    data_v = 1'b1;
    red = r;
    green = g;
    blue = b;
    done = dn;
    model_pix(ref_pix(r, g, b, out_shift));
    if (dn) model_done();
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    data_v = 1'b0;
    done = 1'b0;
    if (!m_first) base_adr = $urandom();
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 3000 && fd_cnt < fd_target; i++) @(posedge clk);
    check("frame_done_timeout", 64'(fd_cnt >= fd_target), 64'd1);
  endtask

  task automatic finish_frame(input logic dn_sent);
    if (!dn_sent) begin
      @(posedge clk);
      #1;
      data_v = 1'b0;
      done = 1'b1;
      model_done();
    end
    idle();
    fd_target++;
    wait_fd();
  endtask

  initial begin
    #2800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_wr_data", wr_data, 64'd0);
    check("reset_wr_adr", {32'h0, wr_adr}, 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Two-pixel frame, shift 8.
    begin_frame(32'h1000, 4'd8);
    send(16'h1234, 16'h5678, 16'h9ABC, 1'b0);
    send(16'hFF00, 16'h0080, 16'h0000, 1'b0);
    finish_frame(1'b0);

    // Saturation at shift 0 and rounding/saturation at shift 4.
    begin_frame(32'h2000, 4'd0);
    send(16'h0100, 16'h00FF, 16'hFFFF, 1'b0);
    send(16'h0000, 16'h0001, 16'h0080, 1'b1);
    finish_frame(1'b1);
    begin_frame(32'h2100, 4'd4);
    send(16'h0FF8, 16'h0017, 16'h0008, 1'b0);
    send(16'h0017, 16'h0FF7, 16'h0007, 1'b0);
    finish_frame(1'b0);

    // Odd pixel count with shift > 8: padded final word.
    begin_frame(32'h1000, 4'd12);
    for (int i = 0; i < 3; i++) send(16'($urandom()), 16'($urandom()), 16'($urandom()), 1'b0);
    finish_frame(1'b0);

    // Address wrap-around, done together with the last pixel.
    begin_frame(32'hFFFF_FFF0, 4'd1);
    for (int i = 0; i < 5; i++) send(16'($urandom()), 16'($urandom()), 16'($urandom()), i == 4);
    finish_frame(1'b1);

    // Empty frame: done while idle.
    @(posedge clk);
    #1 done = 1'b1;
    @(negedge clk);
    check("empty_fd_early", 64'(frame_done), 64'd0);
    @(posedge clk);
    #1 done = 1'b0;
    fd_target++;
    @(negedge clk);
    check("empty_fd_pulse", 64'(frame_done), 64'd1);
    check("empty_no_write", 64'(wr_en), 64'd0);
    @(negedge clk);
    check("empty_fd_single", 64'(frame_done), 64'd0);
    check("empty_no_write2", 64'(wr_en), 64'd0);

    // Randomized frames with gaps and throttled memory.
    ready_mode = 1;
    for (int f = 0; f < 24; f++) begin
      int  n;
      logic dwl;
      n = $urandom_range(1, 20);
      dwl = $urandom_range(0, 1);
      begin_frame($urandom(), 4'($urandom_range(0, 15)));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        send(16'($urandom()), 16'($urandom_range(0, 1023)), 16'($urandom()),
             (i == n - 1) && dwl);
      end
      finish_frame(dwl);
    end

    // Full FIFO under stall, then one dropped word.
    ready_mode = 2;
    m_keep = DEPTH;
    begin_frame(32'h4000, 4'd8);
    for (int i = 0; i < 2 * DEPTH; i++) send(16'($urandom()), 16'($urandom()), 16'($urandom()), 1'b0);
    repeat (6) idle();
    check("full_no_overflow", 64'(overflow), 64'd0);
    check("full_wr_en", 64'(wr_en), 64'd1);
    send(16'h1111, 16'h2222, 16'h3333, 1'b0);
    send(16'h4444, 16'h5555, 16'h6666, 1'b0);
    repeat (6) idle();
    check("overflow_set", 64'(overflow), 64'd1);
    ready_mode = 1;
    finish_frame(1'b0);
    m_keep = 1 << 30;
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Reset in the middle of a stalled frame.
    ready_mode = 2;
    begin_frame(32'h5000, 4'd0);
    for (int i = 0; i < 6; i++) send(16'($urandom()), 16'($urandom()), 16'($urandom()), 1'b0);
    repeat (5) idle();
    check("pre_reset_wr_en", 64'(wr_en), 64'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_wr_en", 64'(wr_en), 64'd0);
    check("midreset_overflow", 64'(overflow), 64'd0);
    check("midreset_wr_data", wr_data, 64'd0);
    exp_d.delete();
    exp_a.delete();
    m_half_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ready_mode = 1;
    begin_frame(32'h6000, 4'd3);
    for (int i = 0; i < 5; i++) send(16'($urandom()), 16'($urandom()), 16'($urandom()), 1'b0);
    finish_frame(1'b0);

    repeat (5) idle();
    check("final_queue_empty", 64'(exp_d.size()), 64'd0);
    check("frame_done_count", 64'(fd_cnt), 64'(fd_target));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
